// File: rtl/mux_n_one_stream_pkg.sv
// rtl/mux_n_one_stream_pkg.sv - shared types and helpers for the N:1 stream multiplexer
package mux_n_one_stream_pkg;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  // Channel index width; a lone channel still needs one bit to carry an index.
  function automatic int sel_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mux_n_one_stream_rr_arbiter.sv
// rtl/mux_n_one_stream_rr_arbiter.sv - combinational round-robin pick starting after last_grant
module rr_arbiter
  import mux_n_one_stream_pkg::*;
#(
  parameter  int N     = 4,
  localparam int SEL_W = sel_width(N)
) (
  input  logic [N-1:0]     req,
  input  logic [SEL_W-1:0] last_grant,
  output logic [SEL_W-1:0] gnt_idx,
  output logic             gnt_any
);

  int idx;

  // Walk offsets from N down to 1 so the nearest requester after last_grant is written last and wins.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    idx     = 0;
    for (int k = N; k >= 1; k--) begin
      idx = (int'(last_grant) + k) % N;
      if (req[idx]) begin
        gnt_any = 1'b1;
        gnt_idx = SEL_W'(idx);
      end
    end
  end

endmodule

// File: rtl/mux_n_one_stream.sv
// rtl/mux_n_one_stream.sv - N:1 valid/ready stream mux, round-robin per packet, registered output
module mux_n_one_stream
  import mux_n_one_stream_pkg::*;
#(
  parameter  int WIDTH       = 8,
  parameter  int N           = 4,
  parameter  int PACKET_MODE = 1,
  localparam int SEL_W       = sel_width(N)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [N-1:0]       in_valid,
  input  logic [N-1:0]       in_last,
  output logic [N-1:0]       in_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic               out_valid,
  output logic               out_last,
  output logic [SEL_W-1:0]   out_channel,
  input  logic               out_ready
);

  state_t             state, state_n;
  logic [SEL_W-1:0]   grant;
  logic [SEL_W-1:0]   last_grant;
  logic [SEL_W-1:0]   arb_idx;
  logic               arb_any;
  logic [WIDTH-1:0]   sel_data;
  logic               sel_valid;
  logic               sel_last;
  logic               slot_free;
  logic               accept;
  logic               end_of_grant;

  rr_arbiter #(.N(N)) u_arb (
    .req        (in_valid),
    .last_grant (last_grant),
    .gnt_idx    (arb_idx),
    .gnt_any    (arb_any)
  );

  always_comb begin
    sel_data  = '0;
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (grant == SEL_W'(i)) begin
        sel_data  = in_data[i*WIDTH +: WIDTH];
        sel_valid = in_valid[i];
        sel_last  = in_last[i];
      end
    end
  end

  // The output register can take a beat when empty or when it is being drained this cycle.
  assign slot_free    = !out_valid || out_ready;
  assign accept       = (state == ST_LOCKED) && sel_valid && slot_free;
  assign end_of_grant = accept && (sel_last || (PACKET_MODE == 0));

  always_comb begin
    state_n  = state;
    in_ready = '0;
    case (state)
      ST_IDLE: begin
        if (arb_any) state_n = ST_LOCKED;
      end
      ST_LOCKED: begin
        for (int i = 0; i < N; i++) begin
          if (grant == SEL_W'(i)) in_ready[i] = slot_free;
        end
        if (end_of_grant) state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      grant       <= '0;
      last_grant  <= SEL_W'(N - 1);
      out_data    <= '0;
      out_valid   <= 1'b0;
      out_last    <= 1'b0;
      out_channel <= '0;
    end else begin
      state <= state_n;
      if (state == ST_IDLE && arb_any) grant <= arb_idx;
      if (end_of_grant) last_grant <= grant;
      if (accept) begin
        out_data    <= sel_data;
        out_last    <= sel_last;
        out_channel <= grant;
        out_valid   <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mux_n_one_stream.sv
// tb/tb_mux_n_one_stream.sv - directed bench for the N:1 stream mux, packet and beat modes
module tb_mux_n_one_stream;

  localparam int WIDTH = 8;
  localparam int N     = 4;
  localparam int SEL_W = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               reset;
  logic               sel;
  logic [N*WIDTH-1:0] p_data;
  logic [N-1:0]       p_valid;
  logic [N-1:0]       p_last;
  logic               out_ready_t;

  logic [N-1:0]       a_in_valid, b_in_valid;
  logic [N-1:0]       a_in_ready, b_in_ready;
  logic [WIDTH-1:0]   a_out_data, b_out_data;
  logic               a_out_valid, b_out_valid;
  logic               a_out_last, b_out_last;
  logic [SEL_W-1:0]   a_out_channel, b_out_channel;

  assign a_in_valid = sel ? '0 : p_valid;
  assign b_in_valid = sel ? p_valid : '0;

  mux_n_one_stream #(.WIDTH(WIDTH), .N(N), .PACKET_MODE(1)) u_pkt (
    .clk(clk), .reset(reset),
    .in_data(p_data), .in_valid(a_in_valid), .in_last(p_last), .in_ready(a_in_ready),
    .out_data(a_out_data), .out_valid(a_out_valid), .out_last(a_out_last),
    .out_channel(a_out_channel), .out_ready(out_ready_t)
  );

  mux_n_one_stream #(.WIDTH(WIDTH), .N(N), .PACKET_MODE(0)) u_beat (
    .clk(clk), .reset(reset),
    .in_data(p_data), .in_valid(b_in_valid), .in_last(p_last), .in_ready(b_in_ready),
    .out_data(b_out_data), .out_valid(b_out_valid), .out_last(b_out_last),
    .out_channel(b_out_channel), .out_ready(out_ready_t)
  );

  logic [N-1:0]     m_in_ready;
  logic [WIDTH-1:0] m_out_data;
  logic             m_out_valid;
  logic             m_out_last;
  logic [SEL_W-1:0] m_out_channel;

  assign m_in_ready    = sel ? b_in_ready    : a_in_ready;
  assign m_out_data    = sel ? b_out_data    : a_out_data;
  assign m_out_valid   = sel ? b_out_valid   : a_out_valid;
  assign m_out_last    = sel ? b_out_last    : a_out_last;
  assign m_out_channel = sel ? b_out_channel : a_out_channel;

  // Producer scripts: {last, data} per beat, per channel.
  logic [8:0]   mem [N][16];
  int           len [N];
  int           ptr [N];
  logic [N-1:0] pen;
  logic [N-1:0] fire_s;

  logic [7:0] obs_d  [64];
  int         obs_c  [64];
  logic       obs_l  [64];
  int         obs_cy [64];
  int         obs_n;
  int         cyc;

  int n_checks;
  int n_pass;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      if (pen[i] && ptr[i] < len[i]) begin
        p_valid[i]              = 1'b1;
        p_data[i*WIDTH +: WIDTH] = mem[i][ptr[i]][7:0];
        p_last[i]               = mem[i][ptr[i]][8];
      end else begin
        p_valid[i]              = 1'b0;
        p_data[i*WIDTH +: WIDTH] = '0;
        p_last[i]               = 1'b0;
      end
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    fire_s = reset ? '0 : (p_valid & m_in_ready);
    if (!reset && m_out_valid && out_ready_t && obs_n < 64) begin
      obs_d[obs_n]  = m_out_data;
      obs_c[obs_n]  = int'(m_out_channel);
      obs_l[obs_n]  = m_out_last;
      obs_cy[obs_n] = cyc;
      obs_n++;
    end
    @(posedge clk);
    #1;
    cyc++;
    for (int i = 0; i < N; i++) if (fire_s[i]) ptr[i]++;
    drive();
  endtask

  task automatic clear_model();
    for (int i = 0; i < N; i++) begin
      len[i] = 0;
      ptr[i] = 0;
    end
    pen   = '0;
    obs_n = 0;
    drive();
  endtask

  task automatic add_beat(input int ch, input logic [7:0] d, input logic l);
    mem[ch][len[ch]] = {l, d};
    len[ch]++;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    clear_model();
    cycle();
    cycle();
    reset = 1'b0;
  endtask

  task automatic run_until(input string tag, input int n, input int budget);
    int k;
    k = 0;
    while (obs_n < n && k < budget) begin
      cycle();
      k++;
    end
    check({tag, "_count"}, obs_n, n);
  endtask

  task automatic chk_beat(input string tag, input int k, input logic [7:0] d, input int ch, input logic l);
    check($sformatf("%s_b%0d_data", tag, k), obs_d[k], d);
    check($sformatf("%s_b%0d_chan", tag, k), obs_c[k], ch);
    check($sformatf("%s_b%0d_last", tag, k), obs_l[k], l);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    n_checks    = 0;
    n_pass      = 0;
    cyc         = 0;
    sel         = 1'b0;
    out_ready_t = 1'b1;
    p_data      = '0;
    p_valid     = '0;
    p_last      = '0;

    do_reset();
    check("rst_out_valid", a_out_valid, 0);
    check("rst_out_data", a_out_data, 0);
    check("rst_out_last", a_out_last, 0);
    check("rst_out_channel", a_out_channel, 0);
    check("rst_in_ready", a_in_ready, 0);
    check("rst_b_out_valid", b_out_valid, 0);

    // Three-beat packet on ch0, then full throughput.
    add_beat(0, 8'h11, 1'b0);
    add_beat(0, 8'h22, 1'b0);
    add_beat(0, 8'h33, 1'b1);
    pen = 4'b0001;
    drive();
    run_until("t1", 3, 20);
    chk_beat("t1", 0, 8'h11, 0, 1'b0);
    chk_beat("t1", 1, 8'h22, 0, 1'b0);
    chk_beat("t1", 2, 8'h33, 0, 1'b1);
    check("t1_gap01", obs_cy[1] - obs_cy[0], 1);
    check("t1_gap12", obs_cy[2] - obs_cy[1], 1);
    repeat (3) cycle();
    check("t1_drained", a_out_valid, 0);
    check("t1_total", obs_n, 3);

    // All four channels with single-beat packets: strict rotation with wrap.
    do_reset();
    add_beat(0, 8'hA0, 1'b1);
    add_beat(0, 8'hA4, 1'b1);
    add_beat(1, 8'hA1, 1'b1);
    add_beat(2, 8'hA2, 1'b1);
    add_beat(3, 8'hA3, 1'b1);
    pen = 4'b1111;
    drive();
    run_until("t2", 5, 40);
    chk_beat("t2", 0, 8'hA0, 0, 1'b1);
    chk_beat("t2", 1, 8'hA1, 1, 1'b1);
    chk_beat("t2", 2, 8'hA2, 2, 1'b1);
    chk_beat("t2", 3, 8'hA3, 3, 1'b1);
    chk_beat("t2", 4, 8'hA4, 0, 1'b1);
    repeat (3) cycle();

    // Two competing two-beat packets never interleave.
    clear_model();
    add_beat(1, 8'hB1, 1'b0);
    add_beat(1, 8'hB2, 1'b1);
    add_beat(2, 8'hC1, 1'b0);
    add_beat(2, 8'hC2, 1'b1);
    pen = 4'b0110;
    drive();
    run_until("t3", 4, 30);
    chk_beat("t3", 0, 8'hB1, 1, 1'b0);
    chk_beat("t3", 1, 8'hB2, 1, 1'b1);
    chk_beat("t3", 2, 8'hC1, 2, 1'b0);
    chk_beat("t3", 3, 8'hC2, 2, 1'b1);
    repeat (3) cycle();

    // Backpressure for five cycles mid-packet.
    clear_model();
    add_beat(0, 8'hD1, 1'b0);
    add_beat(0, 8'hD2, 1'b0);
    add_beat(0, 8'hD3, 1'b0);
    add_beat(0, 8'hD4, 1'b1);
    pen = 4'b0001;
    drive();
    run_until("t4a", 2, 20);
    out_ready_t = 1'b0;
    for (int s = 0; s < 5; s++) begin
      cycle();
      check($sformatf("t4_stall%0d_data", s), a_out_data, 8'hD3);
      check($sformatf("t4_stall%0d_valid", s), a_out_valid, 1);
      check($sformatf("t4_stall%0d_in_ready", s), a_in_ready, 0);
    end
    out_ready_t = 1'b1;
    run_until("t4b", 4, 20);
    repeat (3) cycle();
    check("t4_total", obs_n, 4);
    chk_beat("t4", 0, 8'hD1, 0, 1'b0);
    chk_beat("t4", 1, 8'hD2, 0, 1'b0);
    chk_beat("t4", 2, 8'hD3, 0, 1'b0);
    chk_beat("t4", 3, 8'hD4, 0, 1'b1);

    // Beat mode: ch0 and ch3 alternate with no last markers.
    sel = 1'b1;
    do_reset();
    add_beat(0, 8'hE0, 1'b0);
    add_beat(0, 8'hE1, 1'b0);
    add_beat(0, 8'hE2, 1'b0);
    add_beat(3, 8'hF0, 1'b0);
    add_beat(3, 8'hF1, 1'b0);
    pen = 4'b1001;
    drive();
    run_until("t5", 5, 40);
    chk_beat("t5", 0, 8'hE0, 0, 1'b0);
    chk_beat("t5", 1, 8'hF0, 3, 1'b0);
    chk_beat("t5", 2, 8'hE1, 0, 1'b0);
    chk_beat("t5", 3, 8'hF1, 3, 1'b0);
    chk_beat("t5", 4, 8'hE2, 0, 1'b0);
    repeat (3) cycle();

    // Reset mid-packet on ch2: output clears, ch0 wins the restart.
    sel = 1'b0;
    do_reset();
    add_beat(2, 8'h61, 1'b0);
    add_beat(2, 8'h62, 1'b0);
    add_beat(2, 8'h63, 1'b0);
    add_beat(2, 8'h64, 1'b1);
    add_beat(0, 8'h70, 1'b1);
    pen = 4'b0100;
    drive();
    run_until("t6a", 2, 20);
    chk_beat("t6", 0, 8'h61, 2, 1'b0);
    chk_beat("t6", 1, 8'h62, 2, 1'b0);
    reset = 1'b1;
    pen   = 4'b0101;
    cycle();
    check("t6_rst_out_valid", a_out_valid, 0);
    check("t6_rst_in_ready", a_in_ready, 0);
    check("t6_rst_out_channel", a_out_channel, 0);
    reset = 1'b0;
    run_until("t6b", 4, 20);
    chk_beat("t6", 2, 8'h70, 0, 1'b1);
    chk_beat("t6", 3, 8'h64, 2, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
